// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed seven-segment driver. A snapshot of the BCD inputs is taken once per
// frame and scanned digit by digit with blinking, DP, leading-zero blanking and bad-code flags.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic [3:0] HourH,
  input  logic [3:0] HourL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic [5:0] blink_mask,
  input  logic [5:0] dp_mask,
  input  logic       blank_lz,
  output logic [5:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       frame_tick
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] ScanLast  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FrameLast = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [23:0]   r_snap;
  logic [5:0]    r_snap_dp;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_digit_end;
  logic          w_frame_wrap;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank;

  always_comb begin
    w_digit_end  = (r_scan_cnt == ScanLast);
    w_frame_wrap = w_digit_end && (r_idx == 3'd5);

    case (r_idx)
      3'd0:    w_digit = r_snap[3:0];
      3'd1:    w_digit = r_snap[7:4];
      3'd2:    w_digit = r_snap[11:8];
      3'd3:    w_digit = r_snap[15:12];
      3'd4:    w_digit = r_snap[19:16];
      3'd5:    w_digit = r_snap[23:20];
      default: w_digit = 4'd0;
    endcase

    // Codes A-F show a lone dash so a corrupted counter is visible on the board.
    case (w_digit)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h40;
    endcase

    w_blank = (blink_mask[r_idx] && r_blink_phase) ||
              ((r_idx == 3'd5) && blank_lz && (r_snap[23:20] == 4'd0));
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      r_scan_cnt    <= '0;
      r_idx         <= 3'd0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap        <= 24'd0;
      r_snap_dp     <= 6'd0;
      r_an          <= 6'd0;
      r_seg         <= 7'd0;
      r_dp          <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else if (EN) begin
      r_scan_cnt <= w_digit_end ? '0 : r_scan_cnt + 1'b1;
      if (w_digit_end) begin
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_frame_wrap) begin
        r_snap    <= {HourH, HourL, MinH, MinL, SecH, SecL};
        r_snap_dp <= dp_mask;
        if (r_frame_cnt == FrameLast) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      r_an         <= 6'd1 << r_idx;
      r_seg        <= w_blank ? 7'd0 : w_seg_dec;
      r_dp         <= !w_blank && r_snap_dp[r_idx];
      r_frame_tick <= w_frame_wrap;
    end else begin
      // Counters hold so scanning resumes mid-digit; the display goes dark meanwhile.
      r_an         <= 6'd0;
      r_seg        <= 7'd0;
      r_dp         <= 1'b0;
      r_frame_tick <= 1'b0;
    end
  end

  assign AN         = {6{SEG_ACTIVE_LOW}} ^ r_an;
  assign SEG        = {7{SEG_ACTIVE_LOW}} ^ r_seg;
  assign DP         = SEG_ACTIVE_LOW ^ r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a frame-position reference model queues the expected
// pin state for every clock and a negedge monitor compares it against the DUT.
module tb_bcd_display_scan;

  localparam int ScanDiv     = 4;
  localparam int BlinkFrames = 2;
  localparam int FrameLen    = 6 * ScanDiv;

  logic       CP = 1'b0;
  logic       reset, EN, blank_lz;
  logic [3:0] HourH, HourL, MinH, MinL, SecH, SecL;
  logic [5:0] blink_mask, dp_mask;
  logic [5:0] AN;
  logic [6:0] SEG;
  logic       DP, frame_tick;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t sb_q [$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   model_on = 1'b1;

  int         m_pos, m_frame;
  logic [3:0] m_snap [6];
  logic [5:0] m_snap_dp;

  bcd_display_scan #(
    .SCAN_DIV      (ScanDiv),
    .BLINK_FRAMES  (BlinkFrames),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .CP        (CP),
    .reset     (reset),
    .EN        (EN),
    .HourH     (HourH),
    .HourL     (HourL),
    .MinH      (MinH),
    .MinL      (MinL),
    .SecH      (SecH),
    .SecL      (SecL),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .AN        (AN),
    .SEG       (SEG),
    .DP        (DP),
    .frame_tick(frame_tick)
  );

  always #5 CP = ~CP;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v > 4'd9) ? 7'h40 : tab[v];
  endfunction

  // Reference: position within the frame and number of completed frames since reset.
  always @(posedge CP) begin : ref_model
    exp_t e;
    int   d;
    bit   phase, blank;
    e = '0;
    if (reset) begin
      m_pos     = 0;
      m_frame   = 0;
      m_snap_dp = '0;
      foreach (m_snap[i]) m_snap[i] = 4'd0;
    end else if (EN) begin
      d      = m_pos / ScanDiv;
      phase  = ((m_frame / BlinkFrames) % 2) == 1;
      blank  = (blink_mask[d] && phase) || (d == 5 && blank_lz && m_snap[5] == 4'd0);
      e.an   = 6'(1 << d);
      e.seg  = blank ? 7'h00 : seg_of(m_snap[d]);
      e.dp   = !blank && m_snap_dp[d];
      e.tick = (m_pos == FrameLen - 1);
      if (e.tick) begin
        m_snap    = '{SecL, SecH, MinL, MinH, HourL, HourH};
        m_snap_dp = dp_mask;
        m_frame++;
      end
      m_pos = (m_pos + 1) % FrameLen;
    end
    if (model_on) sb_q.push_back(e);
  end

  always @(negedge CP) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if ({AN, SEG, DP, frame_tick} !== e) begin
        n_miss++;
        $display("FAIL vec %0d pins: got an=%h seg=%h dp=%b tick=%b, exp an=%h seg=%h dp=%b tick=%b",
                 n_vec, AN, SEG, DP, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    HourH = 4'(h / 10); HourL = 4'(h % 10);
    MinH  = 4'(m / 10); MinL  = 4'(m % 10);
    SecH  = 4'(s / 10); SecL  = 4'(s % 10);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FrameLen && m_pos != p; i++) cycles(1);
    n_vec++;
    if (m_pos != p) begin
      n_miss++;
      $display("FAIL wait_pos: got pos %0d, required %0d", m_pos, p);
    end
  endtask

  initial begin
    reset = 1'b1; EN = 1'b0; blank_lz = 1'b0;
    blink_mask = '0; dp_mask = '0;
    set_time(23, 59, 58);
    cycles(2);
    reset = 1'b0; EN = 1'b1;

    // Mid second frame (idx 2): SecL must not tear into the displayed frame.
    cycles(FrameLen + 2 * ScanDiv + 1);
    SecL = 4'd9;
    cycles(2 * FrameLen);

    blink_mask = 6'b000011;
    cycles(6 * FrameLen);

    blink_mask = '0;
    HourH = 4'd0; HourL = 4'hC; blank_lz = 1'b1; dp_mask = 6'b010100;
    cycles(3 * FrameLen);

    // Drop EN with idx 3 at count 1, then resume.
    wait_pos(3 * ScanDiv + 1);
    EN = 1'b0;
    cycles(10);
    EN = 1'b1;
    cycles(2 * FrameLen);

    wait_pos(4 * ScanDiv);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(2 * FrameLen + 4);

    repeat (900) begin
      if ($urandom_range(0, 7) == 0) begin
        HourH = 4'($urandom_range(0, 2));  HourL = 4'($urandom_range(0, 15));
        MinH  = 4'($urandom_range(0, 5));  MinL  = 4'($urandom_range(0, 9));
        SecH  = 4'($urandom_range(0, 15)); SecL  = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 31) == 0) begin
        blink_mask = 6'($urandom);
        dp_mask    = 6'($urandom);
        blank_lz   = 1'($urandom);
      end
      EN    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) == 0);
      cycles(1);
    end

    reset = 1'b0; EN = 1'b1;
    model_on = 1'b0;
    cycles(3);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
